// File: rtl/hero_bus_rr_mux.sv
// ---------------------------------------------------------------------------
// hero_bus_rr_mux
//
// Packet-aware round-robin multiplexer that merges NUM_CH hero write sources
// onto one shared hero bus. A packet is any number of VALID beats closed by a
// single DONE beat; once a channel's VALID beat is accepted the grant stays
// with that channel until its DONE beat is accepted. IDLE beats (cycle type
// 0, and the unused type 3) are consumed but never forwarded.
//
// The output side is a 2-entry skid buffer, so out_ready never reaches the
// input handshake combinationally and one beat per cycle is sustained.
//
// Optional feature, enabled by defining HERO_BUS_RR_MUX_TIMEOUT_EN:
//   a watchdog counts cycles in which the locked owner presents no beat. At
//   TIMEOUT_CYCLES it injects a DONE beat (data 0, out_ch = owner), pulses
//   timeout_err for that cycle and releases the lock. Without the macro
//   timeout_err is constant 0 and a lock is held indefinitely.
//
// Ports:
//   clk          clock
//   rst          asynchronous reset, active-high
//   in_valid     [NUM_CH]             per-channel beat valid
//   in_ready     [NUM_CH]             per-channel beat accept
//   in_cycle     [2*NUM_CH]           per-channel cycle type, ch i at [2i+1:2i]
//   in_data      [NUM_CH*HERO_WIDTH]  per-channel data, ch i at slice i
//   out_valid                         output beat valid (buffer non-empty)
//   out_ready                         downstream accept
//   out_cycle    [2]                  output cycle type (VALID or DONE)
//   out_data     [HERO_WIDTH]         output data
//   out_ch       [$clog2(NUM_CH)]     source channel of the output beat
//   lock_active                       a packet is in progress
//   timeout_err                       one-cycle pulse on watchdog release
// ---------------------------------------------------------------------------
module hero_bus_rr_mux #(
    parameter int NUM_CH         = 4,
    parameter int HERO_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              in_valid,
    output logic [NUM_CH-1:0]              in_ready,
    input  logic [2*NUM_CH-1:0]            in_cycle,
    input  logic [NUM_CH*HERO_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [1:0]                     out_cycle,
    output logic [HERO_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]      out_ch,
    output logic                           lock_active,
    output logic                           timeout_err
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int ENTRY_W = 2 + HERO_WIDTH + CH_W;

    localparam logic [1:0] CYC_VALID = 2'd1;
    localparam logic [1:0] CYC_DONE  = 2'd2;

    // Elaboration-time guard on the supported parameter range.
    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("hero_bus_rr_mux: parameter out of supported range");
    end

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state_reg;
    logic [CH_W-1:0]     rr_ptr_reg;
    logic [CH_W-1:0]     owner_reg;

    // Skid buffer: entry 0 is the head presented on out_*.
    logic [ENTRY_W-1:0]  buf_reg [2];
    logic [1:0]          count_reg;

    logic [1:0]            ch_cycle [NUM_CH];
    logic [HERO_WIDTH-1:0] ch_data  [NUM_CH];

    logic                found;
    logic [CH_W-1:0]     winner;
    logic [CH_W-1:0]     sel;
    logic                sel_valid;
    logic [1:0]          sel_cycle;
    logic                buf_ok;
    logic                grant_ok;
    logic                accept;
    logic                beat_valid;
    logic                beat_done;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  push_entry;
    logic                to_hold;
    logic                to_fire;

    // Split the flat input buses into per-channel views.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign ch_cycle[gi] = in_cycle[2*gi +: 2];
        assign ch_data[gi]  = in_data[HERO_WIDTH*gi +: HERO_WIDTH];
    end

    function automatic logic [CH_W-1:0] ptr_inc(input logic [CH_W-1:0] p);
        return (p == CH_W'(NUM_CH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting at rr_ptr.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_CH;
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = CH_W'(idx);
            end
        end
    end

    assign buf_ok    = (count_reg < 2'd2);
    // A pending watchdog release owns the next buffer slot, so the owner is
    // held off while it waits.
    assign grant_ok  = buf_ok && !to_hold;
    assign sel       = (state_reg == LOCK) ? owner_reg : winner;
    assign sel_valid = (state_reg == LOCK) ? in_valid[owner_reg] : found;
    assign sel_cycle = ch_cycle[sel];
    assign accept    = sel_valid && grant_ok;
    assign beat_valid = (sel_cycle == CYC_VALID);
    assign beat_done  = (sel_cycle == CYC_DONE);

    always_comb begin
        in_ready = '0;
        if (state_reg == LOCK) begin
            in_ready[owner_reg] = grant_ok;
        end else if (found) begin
            in_ready[winner] = grant_ok;
        end
    end

`ifdef HERO_BUS_RR_MUX_TIMEOUT_EN
    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_reg;

    assign to_hold = (state_reg == LOCK) && (to_cnt_reg == TO_LIMIT);
    assign to_fire = to_hold && buf_ok;

    // Held at zero outside LOCK so every new lock starts from zero; saturates
    // at the limit until the synthetic DONE gets a buffer slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_reg <= '0;
        end else if (state_reg != LOCK || accept) begin
            to_cnt_reg <= '0;
        end else if (!in_valid[owner_reg] && !to_hold) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end
`else
    assign to_hold = 1'b0;
    assign to_fire = 1'b0;
`endif

    assign timeout_err = to_fire;

    // Only VALID and DONE beats occupy the buffer.
    assign push = (accept && (beat_valid || beat_done)) || to_fire;
    assign pop  = out_valid && out_ready;
    assign push_entry = to_fire ? {CYC_DONE, {HERO_WIDTH{1'b0}}, owner_reg}
                                : {sel_cycle, ch_data[sel], sel};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ARB;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
        end else begin
            case (state_reg)
                ARB: begin
                    if (accept && beat_valid) begin
                        state_reg <= LOCK;
                        owner_reg <= winner;
                    end else if (accept && beat_done) begin
                        rr_ptr_reg <= ptr_inc(winner);
                    end
                end
                LOCK: begin
                    if (to_fire || (accept && beat_done)) begin
                        rr_ptr_reg <= ptr_inc(owner_reg);
                        state_reg  <= ARB;
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

    // Skid buffer. push is only possible with occupancy < 2 and pop only with
    // occupancy > 0, so the unlisted combinations cannot occur.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            buf_reg[0] <= '0;
            buf_reg[1] <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        buf_reg[0] <= push_entry;
                    end else begin
                        buf_reg[1] <= push_entry;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    buf_reg[0] <= buf_reg[1];
                    count_reg  <= count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == 2'd1) begin
                        buf_reg[0] <= push_entry;
                    end else begin
                        buf_reg[0] <= buf_reg[1];
                        buf_reg[1] <= push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid   = (count_reg != 2'd0);
    assign {out_cycle, out_data, out_ch} = out_valid ? buf_reg[0] : '0;
    assign lock_active = (state_reg == LOCK);

endmodule
